rf_sb: RTL and testbench

Parametrised successor to the core's 32 × 32-bit register file. Adds configurable data width and register count, a second write port, same-cycle write-to-read bypass, and a per-register busy scoreboard. Decode uses the scoreboard to detect RAW hazards on in-flight producers. Sits between decode (read, issue) and the two writeback paths (ALU, load).

---
 rtl/rf_sb.sv | 92 +++++++++
 tb/tb_rf_sb.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_sb.sv
// Parametrised register file with two write ports, same-cycle write-to-read
// bypass and a per-register busy scoreboard for RAW hazard detection.
module rf_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int AW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    output logic            rbusy1,
    output logic            rbusy2,
    input  logic            wen0,
    input  logic [AW-1:0]   waddr0,
    input  logic [XLEN-1:0] wdata0,
    input  logic            wen1,
    input  logic [AW-1:0]   waddr1,
    input  logic [XLEN-1:0] wdata1,
    input  logic            iss,
    input  logic [AW-1:0]   issaddr,
    input  logic            flush,
    output logic            busy_any
);

    logic [XLEN-1:0] mem_q [NREG];
    logic [XLEN-1:0] mem_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    logic hit0_1, hit1_1, hit0_2, hit1_2;

    // Port 1 is applied first so port 0 overwrites it on an address collision.
    always_comb begin
        mem_d = mem_q;
        if (wen1 && waddr1 != '0) mem_d[waddr1] = wdata1;
        if (wen0 && waddr0 != '0) mem_d[waddr0] = wdata0;
        mem_d[0] = '0;
    end

    // Priority rises down the block: write-clear, then flush, then issue-set.
    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r < NREG; r++) begin
            if ((wen0 && waddr0 == AW'(r)) || (wen1 && waddr1 == AW'(r)))
                busy_d[r] = 1'b0;
            if (flush)
                busy_d[r] = 1'b0;
            if (iss && issaddr == AW'(r))
                busy_d[r] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // NOTE: the array is cleared by the asynchronous reset because a reset
    // mid-operation must discard register contents without a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        hit0_1 = wen0 && (waddr0 == raddr1);
        hit1_1 = wen1 && (waddr1 == raddr1);
        hit0_2 = wen0 && (waddr0 == raddr2);
        hit1_2 = wen1 && (waddr1 == raddr2);

        if (raddr1 == '0)  rdata1 = '0;
        else if (hit0_1)   rdata1 = wdata0;
        else if (hit1_1)   rdata1 = wdata1;
        else               rdata1 = mem_q[raddr1];

        if (raddr2 == '0)  rdata2 = '0;
        else if (hit0_2)   rdata2 = wdata0;
        else if (hit1_2)   rdata2 = wdata1;
        else               rdata2 = mem_q[raddr2];

        // A writeback in this cycle is forwarded, so it is not a hazard.
        rbusy1 = busy_q[raddr1] && !(hit0_1 || hit1_1);
        rbusy2 = busy_q[raddr2] && !(hit0_2 || hit1_2);
    end

    assign busy_any = |busy_q;

endmodule

// File: tb/tb_rf_sb.sv
// Scoreboard bench for rf_sb: stimulus pushes expectations, a negedge monitor
// pops and compares them against a 32x32 instance and a 64x16 instance.
module tb_rf_sb;

    localparam int M_R1 = 1, M_R2 = 2, M_B1 = 4, M_B2 = 8, M_BA = 16;

    typedef struct packed {
        logic        dut_b;
        logic [63:0] r1;
        logic [63:0] r2;
        logic        b1;
        logic        b2;
        logic        ba;
        logic [4:0]  mask;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    total = 0;
    int    bad   = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: 32 x 32
    logic [4:0]  a_raddr1 = '0, a_raddr2 = '0, a_waddr0 = '0, a_waddr1 = '0, a_issaddr = '0;
    logic [31:0] a_wdata0 = '0, a_wdata1 = '0, a_rdata1, a_rdata2;
    logic        a_wen0 = 0, a_wen1 = 0, a_iss = 0, a_flush = 0;
    logic        a_rbusy1, a_rbusy2, a_busy_any;

    // Instance B: 64 x 16
    logic [3:0]  b_raddr1 = '0, b_raddr2 = '0, b_waddr0 = '0, b_waddr1 = '0, b_issaddr = '0;
    logic [63:0] b_wdata0 = '0, b_wdata1 = '0, b_rdata1, b_rdata2;
    logic        b_wen0 = 0, b_wen1 = 0, b_iss = 0, b_flush = 0;
    logic        b_rbusy1, b_rbusy2, b_busy_any;

    rf_sb #(.XLEN(32), .NREG(32)) u_a (
        .clk(clk), .rst(rst),
        .raddr1(a_raddr1), .raddr2(a_raddr2), .rdata1(a_rdata1), .rdata2(a_rdata2),
        .rbusy1(a_rbusy1), .rbusy2(a_rbusy2),
        .wen0(a_wen0), .waddr0(a_waddr0), .wdata0(a_wdata0),
        .wen1(a_wen1), .waddr1(a_waddr1), .wdata1(a_wdata1),
        .iss(a_iss), .issaddr(a_issaddr), .flush(a_flush), .busy_any(a_busy_any)
    );

    rf_sb #(.XLEN(64), .NREG(16)) u_b (
        .clk(clk), .rst(rst),
        .raddr1(b_raddr1), .raddr2(b_raddr2), .rdata1(b_rdata1), .rdata2(b_rdata2),
        .rbusy1(b_rbusy1), .rbusy2(b_rbusy2),
        .wen0(b_wen0), .waddr0(b_waddr0), .wdata0(b_wdata0),
        .wen1(b_wen1), .waddr1(b_waddr1), .wdata1(b_wdata1),
        .iss(b_iss), .issaddr(b_issaddr), .flush(b_flush), .busy_any(b_busy_any)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every expectation queued since the last edge is compared here.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t  e;
            string n;
            logic [63:0] r1, r2;
            logic b1, b2, ba;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            if (e.dut_b) begin
                r1 = b_rdata1; r2 = b_rdata2; b1 = b_rbusy1; b2 = b_rbusy2; ba = b_busy_any;
            end else begin
                r1 = 64'(a_rdata1); r2 = 64'(a_rdata2);
                b1 = a_rbusy1; b2 = a_rbusy2; ba = a_busy_any;
            end
            if (e.mask[0]) check({n, ".rdata1"}, r1, e.r1);
            if (e.mask[1]) check({n, ".rdata2"}, r2, e.r2);
            if (e.mask[2]) check({n, ".rbusy1"}, 64'(b1), 64'(e.b1));
            if (e.mask[3]) check({n, ".rbusy2"}, 64'(b2), 64'(e.b2));
            if (e.mask[4]) check({n, ".busy_any"}, 64'(ba), 64'(e.ba));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        a_wen0 = 0; a_wen1 = 0; a_iss = 0; a_flush = 0;
        b_wen0 = 0; b_wen1 = 0; b_iss = 0; b_flush = 0;
    endtask

    task automatic expect_out(input string name, input logic dut_b, input int mask,
                              input logic [63:0] r1, input logic [63:0] r2,
                              input logic b1, input logic b2, input logic ba);
        exp_t e;
        e.dut_b = dut_b; e.r1 = r1; e.r2 = r2;
        e.b1 = b1; e.b2 = b2; e.ba = ba; e.mask = mask[4:0];
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    task automatic wr_a(input int port, input logic [4:0] addr, input logic [31:0] data);
        if (port == 0) begin a_wen0 = 1; a_waddr0 = addr; a_wdata0 = data; end
        else           begin a_wen1 = 1; a_waddr1 = addr; a_wdata1 = data; end
    endtask

    initial begin
        // Held in reset: stored data is zero, bypass still forwards
        step();
        a_raddr1 = 5; a_raddr2 = 6; wr_a(0, 6, 32'h77);
        expect_out("rst_hold", 0, M_R1 | M_R2 | M_B1 | M_BA, 0, 64'h77, 0, 0, 0);
        step();
        rst = 0;
        expect_out("rst_write_ignored", 0, M_R2, 0, 0, 0, 0, 0);

        step();
        wr_a(0, 5, 32'h1234);
        expect_out("x5_bypass", 0, M_R1, 64'h1234, 0, 0, 0, 0);
        step();
        a_iss = 1; a_issaddr = 12; a_raddr2 = 12;
        expect_out("x5_mem", 0, M_R1 | M_B2, 64'h1234, 0, 0, 0, 0);
        step();
        expect_out("pre_rst", 0, M_R1 | M_B2 | M_BA, 64'h1234, 0, 0, 1, 1);
        step();
        rst = 1;  // asserted mid-cycle, no edge before the monitor samples
        expect_out("async_rst", 0, M_R1 | M_B2 | M_BA, 0, 0, 0, 0, 0);
        step();
        rst = 0;

        // Index 0 is hard-wired zero
        step();
        a_raddr1 = 0; wr_a(0, 0, 32'hFFFF);
        expect_out("x0_bypass", 0, M_R1 | M_B1, 0, 0, 0, 0, 0);
        step();
        expect_out("x0_mem", 0, M_R1, 0, 0, 0, 0, 0);

        // Same-address dual write: port 0 wins
        step();
        a_raddr1 = 3; wr_a(0, 3, 32'hAAAA); wr_a(1, 3, 32'h5555);
        expect_out("prio_bypass", 0, M_R1, 64'hAAAA, 0, 0, 0, 0);
        step();
        expect_out("prio_mem", 0, M_R1, 64'hAAAA, 0, 0, 0, 0);

        // Port-1 bypass alongside a port-0 write elsewhere
        step();
        a_raddr1 = 8; a_raddr2 = 7; wr_a(1, 7, 32'hBEEF); wr_a(0, 8, 32'h8888);
        expect_out("p1_bypass", 0, M_R1 | M_R2, 64'h8888, 64'hBEEF, 0, 0, 0);
        step();
        expect_out("p1_mem", 0, M_R1 | M_R2, 64'h8888, 64'hBEEF, 0, 0, 0);

        // RAW: issue x4, clear by load writeback in cycle 3
        step();
        a_raddr1 = 4; a_iss = 1; a_issaddr = 4;
        expect_out("raw_c0", 0, M_B1 | M_BA, 0, 0, 0, 0, 0);
        step();
        expect_out("raw_c1", 0, M_B1 | M_BA, 0, 0, 1, 0, 1);
        step();
        expect_out("raw_c2", 0, M_B1 | M_BA, 0, 0, 1, 0, 1);
        step();
        wr_a(1, 4, 32'h42);
        expect_out("raw_c3", 0, M_R1 | M_B1 | M_BA, 64'h42, 0, 0, 0, 1);
        step();
        expect_out("raw_c4", 0, M_R1 | M_B1 | M_BA, 64'h42, 0, 0, 0, 0);

        // Issue wins over same-edge write-clear
        step();
        a_raddr1 = 9; a_iss = 1; a_issaddr = 9;
        step();
        a_iss = 1; a_issaddr = 9; wr_a(0, 9, 32'h99);
        expect_out("soc_same", 0, M_R1 | M_B1 | M_BA, 64'h99, 0, 0, 0, 1);
        step();
        expect_out("soc_after", 0, M_R1 | M_B1 | M_BA, 64'h99, 0, 1, 0, 1);

        // Issue wins over same-edge flush; everything else clears
        step();
        a_raddr2 = 10; a_iss = 1; a_issaddr = 10; a_flush = 1;
        expect_out("fl_same", 0, M_B1 | M_B2, 0, 0, 1, 0, 0);
        step();
        expect_out("fl_after", 0, M_B1 | M_B2 | M_BA, 0, 0, 0, 1, 1);
        step();
        a_flush = 1;
        step();
        expect_out("fl_all", 0, M_B2 | M_BA, 0, 0, 0, 0, 0);

        // Issue to x0 is ignored
        step();
        a_raddr1 = 0; a_iss = 1; a_issaddr = 0;
        step();
        expect_out("x0_iss", 0, M_B1 | M_BA, 0, 0, 0, 0, 0);

        // 64-bit, 16-register instance, top index
        step();
        b_raddr1 = 15; b_wen0 = 1; b_waddr0 = 15; b_wdata0 = 64'hDEADBEEF_CAFEF00D;
        expect_out("b_bypass", 1, M_R1, 64'hDEADBEEF_CAFEF00D, 0, 0, 0, 0);
        step();
        b_iss = 1; b_issaddr = 15;
        expect_out("b_mem", 1, M_R1 | M_B1, 64'hDEADBEEF_CAFEF00D, 0, 0, 0, 0);
        step();
        b_flush = 1;
        expect_out("b_busy", 1, M_B1 | M_BA, 0, 0, 1, 0, 1);
        step();
        expect_out("b_flushed", 1, M_B1 | M_BA, 0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
